key_expander: RTL



---
 rtl/key_expander.sv | 122 ++++++++++++
 1 files changed

// File: rtl/key_expander.sv
// Round-key generator: requests a 16-bit key, then emits NUM_ROUNDS round keys over valid/ready.
// Optional macro KEYEXP_ROUND_CONST_EN compiles in the round-constant XOR into the low nibble.
module key_expander #(
  parameter int unsigned NUM_ROUNDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  output logic        o_key_req,
  input  logic [15:0] i_key_in,
  output logic [15:0] o_rk_data,
  output logic [3:0]  o_rk_idx,
  output logic        o_rk_valid,
  input  logic        i_rk_ready,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned KEY_W = 16;
  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [KEY_W-1:0]   r_k;
  logic [KEY_W-1:0]   w_k_nxt;
  logic [IDX_W-1:0]   r_r;
  logic [IDX_W-1:0]   w_r_nxt;
  logic               r_key_req;
  logic               r_rk_valid;
  logic               r_busy;
  logic               r_done;
  logic               w_done_nxt;
  logic [KEY_W-1:0]   w_sub;
  logic [3:0]         w_amt;
  logic [KEY_W-1:0]   w_rot;
  logic [KEY_W-1:0]   w_next_key;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    case (n)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  // Next-key datapath: substitute, rotate by the substituted low nibble, optional round constant
  always_comb begin
    w_sub = {sbox(r_k[15:12]), sbox(r_k[11:8]), sbox(r_k[7:4]), sbox(r_k[3:0])};
    w_amt = w_sub[3:0];
    w_rot = (w_sub << w_amt) | (w_sub >> (5'd16 - {1'b0, w_amt}));
`ifdef KEYEXP_ROUND_CONST_EN
    w_next_key = {w_rot[15:4], w_rot[3:0] ^ (r_r + 4'd1)};
`else
    w_next_key = w_rot;
`endif
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_r_nxt     = r_r;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped
        if (i_start && !r_done) w_state_nxt = S_REQ;
      end
      S_REQ:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        w_k_nxt     = i_key_in;
        w_r_nxt     = '0;
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        if (i_rk_ready) begin
          if (r_r == LAST_IDX) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_k_nxt = w_next_key;
            w_r_nxt = r_r + 4'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and output registers; outputs are pre-decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_r        <= '0;
      r_key_req  <= 1'b0;
      r_rk_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_r        <= w_r_nxt;
      r_key_req  <= (w_state_nxt == S_REQ);
      r_rk_valid <= (w_state_nxt == S_EMIT);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
    end
  end

  assign o_key_req  = r_key_req;
  assign o_rk_valid = r_rk_valid;
  assign o_rk_data  = r_k;
  assign o_rk_idx   = r_r;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule
